// File: rtl/speck_key_expander.sv
// Streaming SPECK key schedule for any standard n/m variant. It takes an m-word
// master key and emits one n-bit round key per valid/ready handshake.
module speck_key_expander #(
  parameter int WORD_SIZE = 32,
  parameter int KEY_WORDS = 4,
  parameter int ROUNDS    = 27,
  parameter int ALPHA     = 8,
  parameter int BETA      = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WORD_SIZE*KEY_WORDS-1:0] key,
  input  logic                           key_valid,
  output logic                           key_ready,
  input  logic                           abort,
  output logic [WORD_SIZE-1:0]           rk,
  output logic [7:0]                     rk_index,
  output logic                           rk_valid,
  input  logic                           rk_ready,
  output logic                           rk_last,
  output logic                           busy
);

  localparam int         LW       = KEY_WORDS - 1;
  localparam logic [7:0] LAST_IDX = 8'(ROUNDS - 1);

  if (!(WORD_SIZE == 16 || WORD_SIZE == 24 || WORD_SIZE == 32 ||
        WORD_SIZE == 48 || WORD_SIZE == 64)) begin : g_bad_word_size
    $error("speck_key_expander: WORD_SIZE must be 16, 24, 32, 48 or 64");
  end
  if (!(KEY_WORDS >= 2 && KEY_WORDS <= 4)) begin : g_bad_key_words
    $error("speck_key_expander: KEY_WORDS must be 2, 3 or 4");
  end
  if (!(ROUNDS >= 1 && ROUNDS <= 255)) begin : g_bad_rounds
    $error("speck_key_expander: ROUNDS must be in 1..255");
  end
  if (ALPHA != ((WORD_SIZE == 16) ? 7 : 8) ||
      BETA  != ((WORD_SIZE == 16) ? 2 : 3)) begin : g_bad_rotates
    $error("speck_key_expander: ALPHA/BETA do not match WORD_SIZE");
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t               state_q;
  logic [WORD_SIZE-1:0] k_q;
  logic [WORD_SIZE-1:0] l_q [LW];
  logic [7:0]           i_q;
  logic                 key_ready_q;
  logic                 rk_valid_q;
  logic                 rk_last_q;
  logic                 busy_q;
  logic [WORD_SIZE-1:0] new_l_d;
  logic [WORD_SIZE-1:0] k_d;

  function automatic logic [WORD_SIZE-1:0] ror(input logic [WORD_SIZE-1:0] x, input int r);
    return (x >> r) | (x << (WORD_SIZE - r));
  endfunction

  function automatic logic [WORD_SIZE-1:0] rol(input logic [WORD_SIZE-1:0] x, input int r);
    return (x << r) | (x >> (WORD_SIZE - r));
  endfunction

  // One schedule step from the key currently presented on rk.
  always_comb begin
    new_l_d = (k_q + ror(l_q[0], ALPHA)) ^ {{(WORD_SIZE-8){1'b0}}, i_q};
    k_d     = rol(k_q, BETA) ^ new_l_d;
  end

  // Control FSM and schedule registers; abort overrides everything but reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= {WORD_SIZE{1'b0}};
      for (int j = 0; j < LW; j++) l_q[j] <= {WORD_SIZE{1'b0}};
      i_q         <= 8'd0;
      key_ready_q <= 1'b1;
      rk_valid_q  <= 1'b0;
      rk_last_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= S_IDLE;
      i_q         <= 8'd0;
      key_ready_q <= 1'b1;
      rk_valid_q  <= 1'b0;
      rk_last_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (key_valid && key_ready_q) begin
            k_q <= key[WORD_SIZE-1:0];
            for (int j = 0; j < LW; j++) l_q[j] <= key[(j+1)*WORD_SIZE +: WORD_SIZE];
            i_q         <= 8'd0;
            state_q     <= S_EMIT;
            key_ready_q <= 1'b0;
            rk_valid_q  <= 1'b1;
            rk_last_q   <= (LAST_IDX == 8'd0);
            busy_q      <= 1'b1;
          end
        end
        S_EMIT: begin
          if (rk_ready) begin
            if (i_q == LAST_IDX) begin
              state_q     <= S_IDLE;
              key_ready_q <= 1'b1;
              rk_valid_q  <= 1'b0;
              rk_last_q   <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              // With m=2 the loop is empty and the single l slot is overwritten.
              k_q <= k_d;
              for (int j = 0; j < LW - 1; j++) l_q[j] <= l_q[j+1];
              l_q[LW-1] <= new_l_d;
              i_q       <= i_q + 8'd1;
              rk_last_q <= ((i_q + 8'd1) == LAST_IDX);
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          i_q         <= 8'd0;
          key_ready_q <= 1'b1;
          rk_valid_q  <= 1'b0;
          rk_last_q   <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign key_ready = key_ready_q;
  assign rk        = k_q;
  assign rk_index  = i_q;
  assign rk_valid  = rk_valid_q;
  assign rk_last   = rk_last_q;
  assign busy      = busy_q;

endmodule
